// File: rtl/instr_fetch_loader_pkg.sv
// ---------------------------------------------------------------------------
// instr_fetch_loader_pkg
//   Shared definitions for the instruction fetch/loader stage that sits in
//   front of the 8-bit single-cycle core.
//
//   Contents:
//     - state encodings for the loader FSM (IDLE / LOAD / RUN / HALT)
//     - the halt instruction (branch-to-self, opcode 11, imm -1)
//     - opcode field position and values, shared with the core's control unit
//     - a small helper that extracts the opcode field from an instruction
// ---------------------------------------------------------------------------
package instr_fetch_loader_pkg;

  // State encodings, kept as plain constants so other blocks (debug muxes,
  // status registers) can decode the state without pulling in the enum type.
  localparam logic [1:0] STATE_IDLE = 2'd0;
  localparam logic [1:0] STATE_LOAD = 2'd1;
  localparam logic [1:0] STATE_RUN  = 2'd2;
  localparam logic [1:0] STATE_HALT = 2'd3;

  typedef enum logic [1:0] {
    IDLE = STATE_IDLE,
    LOAD = STATE_LOAD,
    RUN  = STATE_RUN,
    HALT = STATE_HALT
  } fetchState_t;

  // Branch-to-self: opcode 11 (branch) with a 2-bit immediate of -1, so the
  // core keeps re-executing the same PC without disturbing its registers.
  localparam logic [7:0] HALT_INSTR_DEFAULT = 8'hC3;

  // Opcode field lives in the two most significant instruction bits.
  localparam int OPC_MSB = 7;
  localparam int OPC_LSB = 6;

  localparam logic [1:0] OPC_ALU    = 2'b00;
  localparam logic [1:0] OPC_LOAD   = 2'b01;
  localparam logic [1:0] OPC_STORE  = 2'b10;
  localparam logic [1:0] OPC_BRANCH = 2'b11;

  function automatic logic [1:0] opcodeOf(input logic [7:0] instr);
    return instr[OPC_MSB:OPC_LSB];
  endfunction

endpackage

// File: rtl/instr_fetch_loader_ram.sv
// ---------------------------------------------------------------------------
// instr_ram
//   Program storage for the fetch loader: DEPTH x DATA_W words with a
//   synchronous write port (driven by the byte loader) and an asynchronous
//   read port (driven by the core's PC). The read must be combinational so
//   the core sees its instruction in the same cycle it presents the PC.
//
//   Ports:
//     clk     in   clock
//     wrEn    in   write strobe, one word per cycle
//     wrAddr  in   write address
//     wrData  in   write data
//     rdAddr  in   read address (core PC)
//     rdData  out  read data, combinational from rdAddr
//
//   Contents are never reset; an image is only meaningful after a load.
// ---------------------------------------------------------------------------
module instr_ram
  import instr_fetch_loader_pkg::*;
#(
  parameter int DEPTH  = 256,
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              wrEn,
  input  logic [ADDR_W-1:0] wrAddr,
  input  logic [DATA_W-1:0] wrData,
  input  logic [ADDR_W-1:0] rdAddr,
  output logic [DATA_W-1:0] rdData
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wrEn) begin
      mem[wrAddr] <= wrData;
    end
  end

  assign rdData = mem[rdAddr];

endmodule

// File: rtl/instr_fetch_loader.sv
// ---------------------------------------------------------------------------
// instr_fetch_loader
//   Instruction-side stage directly upstream of the 8-bit core. A program is
//   streamed in byte by byte over a valid/ready port into a local RAM; the
//   loader holds the core in reset while loading, releases it to run the
//   program, and substitutes a branch-to-self halt once the core's PC walks
//   past the end of the loaded image.
//
//   Ports:
//     clk          in   clock shared with the core
//     RST          in   asynchronous active-high reset
//     load_start   in   pulse: begin a new program load
//     load_valid   in   load byte present
//     load_data    in   [8] instruction byte
//     load_last    in   marks the final byte of the program
//     load_ready   out  a byte is accepted this cycle when load_valid is high
//     run_start    in   pulse: rerun the loaded program from PC 0
//     pc_in        in   [8] core PC
//     instruction  out  [8] instruction for the core, combinational from pc_in
//     cpu_rst      out  registered reset to the core
//     halted       out  program ran off its end
//     prog_len     out  [9] loaded program length, 0..256
//     instr_count  out  [CNT_W] cycles spent in RUN, saturating
// ---------------------------------------------------------------------------
module instr_fetch_loader
  import instr_fetch_loader_pkg::*;
#(
  parameter int         DEPTH      = 256,
  parameter logic [7:0] HALT_INSTR = HALT_INSTR_DEFAULT,
  parameter int         CNT_W      = 16
) (
  input  logic             clk,
  input  logic             RST,
  input  logic             load_start,
  input  logic             load_valid,
  input  logic [7:0]       load_data,
  input  logic             load_last,
  output logic             load_ready,
  input  logic             run_start,
  input  logic [7:0]       pc_in,
  output logic [7:0]       instruction,
  output logic             cpu_rst,
  output logic             halted,
  output logic [8:0]       prog_len,
  output logic [CNT_W-1:0] instr_count
);

  localparam logic [7:0] LAST_ADDR = 8'(DEPTH - 1);

  fetchState_t      stateReg;
  fetchState_t      stateNext;
  logic [7:0]       wrPtr;
  logic [8:0]       progLenReg;
  logic             haltedReg;
  logic             cpuRstReg;
  logic [CNT_W-1:0] countReg;
  // Set for the single IDLE cycle that follows a rerun request from HALT,
  // so IDLE continues into RUN on its own.
  logic             rerunPending;

  logic             beatAccept;
  logic             beatFinal;
  logic             pcInRange;
  logic             enterLoad;
  logic             enterRun;
  logic [7:0]       ramData;

  // -------------------------------------------------------------------------
  // Load handshake and range test
  // -------------------------------------------------------------------------
  assign load_ready = (stateReg == LOAD);
  assign beatAccept = load_valid && load_ready;
  // The last RAM slot closes the image even without load_last, since there
  // is nowhere left to put another byte.
  assign beatFinal  = beatAccept && (load_last || (wrPtr == LAST_ADDR));
  // Compare at 9 bits so a full 256-byte image covers every PC value.
  assign pcInRange  = ({1'b0, pc_in} < progLenReg);

  // -------------------------------------------------------------------------
  // Next-state and instruction mux
  // -------------------------------------------------------------------------
  always_comb begin
    stateNext   = stateReg;
    instruction = HALT_INSTR;

    case (stateReg)
      IDLE: begin
        if (load_start) begin
          stateNext = LOAD;
        end else if (rerunPending) begin
          stateNext = RUN;
        end else if (run_start && (progLenReg != 9'd0)) begin
          stateNext = RUN;
        end
      end

      LOAD: begin
        // load_start / run_start have no effect until the image is complete.
        if (beatFinal) begin
          stateNext = RUN;
        end
      end

      RUN: begin
        if (pcInRange) begin
          instruction = ramData;
        end
        if (load_start) begin
          stateNext = LOAD;
        end else if (!pcInRange) begin
          stateNext = HALT;
        end
      end

      HALT: begin
        if (load_start) begin
          stateNext = LOAD;
        end else if (run_start) begin
          stateNext = IDLE;
        end
      end

      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  assign enterLoad = (stateNext == LOAD) && (stateReg != LOAD);
  assign enterRun  = (stateNext == RUN)  && (stateReg != RUN);

  // -------------------------------------------------------------------------
  // State, pointer, length, status and counter registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      stateReg     <= IDLE;
      cpuRstReg    <= 1'b1;
      haltedReg    <= 1'b0;
      progLenReg   <= 9'd0;
      countReg     <= '0;
      wrPtr        <= 8'd0;
      rerunPending <= 1'b0;
    end else begin
      stateReg <= stateNext;

      // Driven from the next state so the core leaves reset on the very
      // first RUN cycle and sees PC 0 there. HALT keeps the core out of
      // reset so its registers and display survive.
      cpuRstReg <= !((stateNext == RUN) || (stateNext == HALT));

      rerunPending <= (stateReg == HALT) && (stateNext == IDLE);

      if (enterLoad) begin
        wrPtr      <= 8'd0;
        progLenReg <= 9'd0;
      end else if (beatAccept) begin
        wrPtr <= wrPtr + 8'd1;
        if (beatFinal) begin
          progLenReg <= {1'b0, wrPtr} + 9'd1;
        end
      end

      if (enterLoad || ((stateReg == HALT) && (stateNext != HALT))) begin
        haltedReg <= 1'b0;
      end else if ((stateReg == RUN) && (stateNext == HALT)) begin
        haltedReg <= 1'b1;
      end

      if (enterRun) begin
        countReg <= '0;
      end else if ((stateReg == RUN) && (countReg != '1)) begin
        countReg <= countReg + 1'b1;
      end
    end
  end

  assign cpu_rst     = cpuRstReg;
  assign halted      = haltedReg;
  assign prog_len    = progLenReg;
  assign instr_count = countReg;

  // -------------------------------------------------------------------------
  // Program RAM
  // -------------------------------------------------------------------------
  instr_ram #(
    .DEPTH (DEPTH),
    .DATA_W(8),
    .ADDR_W(8)
  ) u_instr_ram (
    .clk   (clk),
    .wrEn  (beatAccept),
    .wrAddr(wrPtr),
    .wrData(load_data),
    .rdAddr(pc_in),
    .rdData(ramData)
  );

endmodule

// File: tb/tb_instr_fetch_loader.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch_loader
//   Directed bench for instr_fetch_loader. Each scenario task drives its own
//   stimulus and compares outputs against hand-computed values. Scenarios run
//   back to back and rely on the state left by the previous one.
// ---------------------------------------------------------------------------
module tb_instr_fetch_loader;

  logic        clk;
  logic        RST;
  logic        load_start;
  logic        load_valid;
  logic [7:0]  load_data;
  logic        load_last;
  logic        load_ready;
  logic        run_start;
  logic [7:0]  pc_in;
  logic [7:0]  instruction;
  logic        cpu_rst;
  logic        halted;
  logic [8:0]  prog_len;
  logic [15:0] instr_count;

  int checks   = 0;
  int failures = 0;

  instr_fetch_loader dut (
    .clk        (clk),
    .RST        (RST),
    .load_start (load_start),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_last  (load_last),
    .load_ready (load_ready),
    .run_start  (run_start),
    .pc_in      (pc_in),
    .instruction(instruction),
    .cpu_rst    (cpu_rst),
    .halted     (halted),
    .prog_len   (prog_len),
    .instr_count(instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    RST = 1'b0;
    load_start = 1'b0; load_valid = 1'b0; load_data = 8'h00; load_last = 1'b0;
    run_start = 1'b0; pc_in = 8'h00;
    #3 RST = 1'b1;   // mid-cycle, no clock edge involved
    #1;
    checks++; if (cpu_rst !== 1'b1) begin failures++; $display("FAIL reset_cpu_rst: got %b want 1", cpu_rst); end
    checks++; if (load_ready !== 1'b0) begin failures++; $display("FAIL reset_load_ready: got %b want 0", load_ready); end
    checks++; if (prog_len !== 9'd0) begin failures++; $display("FAIL reset_prog_len: got %0d want 0", prog_len); end
    checks++; if (instruction !== 8'hC3) begin failures++; $display("FAIL reset_instruction: got %h want c3", instruction); end
    checks++; if (halted !== 1'b0) begin failures++; $display("FAIL reset_halted: got %b want 0", halted); end
    checks++; if (instr_count !== 16'd0) begin failures++; $display("FAIL reset_instr_count: got %0d want 0", instr_count); end
    tick();
    tick();
    RST = 1'b0;
    tick();
    $display("reset: cpu_rst=%b load_ready=%b prog_len=%0d", cpu_rst, load_ready, prog_len);
  endtask

  task automatic test_load3();
    load_start = 1'b1; tick(); load_start = 1'b0;
    checks++; if (load_ready !== 1'b1) begin failures++; $display("FAIL load3_ready: got %b want 1", load_ready); end
    checks++; if (cpu_rst !== 1'b1) begin failures++; $display("FAIL load3_cpu_rst_loading: got %b want 1", cpu_rst); end
    load_valid = 1'b1; load_data = 8'h11; tick();
    load_valid = 1'b0; load_data = 8'hEE; tick();   // gap cycle must not write
    load_valid = 1'b1; load_data = 8'h22; tick();
    load_valid = 1'b1; load_data = 8'h33; load_last = 1'b1; tick();
    load_valid = 1'b0; load_last = 1'b0;
    checks++; if (cpu_rst !== 1'b0) begin failures++; $display("FAIL load3_cpu_rst_run: got %b want 0", cpu_rst); end
    checks++; if (prog_len !== 9'd3) begin failures++; $display("FAIL load3_prog_len: got %0d want 3", prog_len); end
    checks++; if (load_ready !== 1'b0) begin failures++; $display("FAIL load3_ready_run: got %b want 0", load_ready); end
    checks++; if (instr_count !== 16'd0) begin failures++; $display("FAIL load3_count_entry: got %0d want 0", instr_count); end
    pc_in = 8'd0; #1;
    checks++; if (instruction !== 8'h11) begin failures++; $display("FAIL load3_pc0: got %h want 11", instruction); end
    tick(); pc_in = 8'd1; #1;
    checks++; if (instruction !== 8'h22) begin failures++; $display("FAIL load3_pc1: got %h want 22", instruction); end
    tick(); pc_in = 8'd2; #1;
    checks++; if (instruction !== 8'h33) begin failures++; $display("FAIL load3_pc2: got %h want 33", instruction); end
    checks++; if (halted !== 1'b0) begin failures++; $display("FAIL load3_halted: got %b want 0", halted); end
    tick();
    $display("load3: prog_len=%0d instr_count=%0d", prog_len, instr_count);
  endtask

  task automatic test_runoff();
    pc_in = 8'd3; #1;
    checks++; if (instruction !== 8'hC3) begin failures++; $display("FAIL runoff_instr_same_cycle: got %h want c3", instruction); end
    checks++; if (halted !== 1'b0) begin failures++; $display("FAIL runoff_halted_early: got %b want 0", halted); end
    tick();
    checks++; if (halted !== 1'b1) begin failures++; $display("FAIL runoff_halted: got %b want 1", halted); end
    checks++; if (instr_count !== 16'd4) begin failures++; $display("FAIL runoff_count: got %0d want 4", instr_count); end
    checks++; if (cpu_rst !== 1'b0) begin failures++; $display("FAIL runoff_cpu_rst: got %b want 0", cpu_rst); end
    tick(); tick(); tick();
    checks++; if (instr_count !== 16'd4) begin failures++; $display("FAIL runoff_count_frozen: got %0d want 4", instr_count); end
    checks++; if (halted !== 1'b1) begin failures++; $display("FAIL runoff_halted_hold: got %b want 1", halted); end
    checks++; if (instruction !== 8'hC3) begin failures++; $display("FAIL runoff_instr_hold: got %h want c3", instruction); end
    $display("runoff: halted=%b instr_count=%0d", halted, instr_count);
  endtask

  task automatic test_rerun();
    run_start = 1'b1; tick(); run_start = 1'b0;
    checks++; if (cpu_rst !== 1'b1) begin failures++; $display("FAIL rerun_idle_cpu_rst: got %b want 1", cpu_rst); end
    checks++; if (halted !== 1'b0) begin failures++; $display("FAIL rerun_halted_clear: got %b want 0", halted); end
    checks++; if (instruction !== 8'hC3) begin failures++; $display("FAIL rerun_idle_instr: got %h want c3", instruction); end
    pc_in = 8'd0;
    tick();
    checks++; if (cpu_rst !== 1'b0) begin failures++; $display("FAIL rerun_run_cpu_rst: got %b want 0", cpu_rst); end
    checks++; if (instr_count !== 16'd0) begin failures++; $display("FAIL rerun_count_restart: got %0d want 0", instr_count); end
    checks++; if (instruction !== 8'h11) begin failures++; $display("FAIL rerun_pc0: got %h want 11", instruction); end
    checks++; if (prog_len !== 9'd3) begin failures++; $display("FAIL rerun_prog_len: got %0d want 3", prog_len); end
    tick();
    checks++; if (instr_count !== 16'd1) begin failures++; $display("FAIL rerun_count_inc: got %0d want 1", instr_count); end
    $display("rerun: cpu_rst=%b instr_count=%0d", cpu_rst, instr_count);
  endtask

  task automatic test_priority();
    load_start = 1'b1; run_start = 1'b1; tick();
    load_start = 1'b0; run_start = 1'b0;
    checks++; if (load_ready !== 1'b1) begin failures++; $display("FAIL priority_load_ready: got %b want 1", load_ready); end
    checks++; if (cpu_rst !== 1'b1) begin failures++; $display("FAIL priority_cpu_rst: got %b want 1", cpu_rst); end
    checks++; if (prog_len !== 9'd0) begin failures++; $display("FAIL priority_prog_len: got %0d want 0", prog_len); end
    checks++; if (instruction !== 8'hC3) begin failures++; $display("FAIL priority_instr: got %h want c3", instruction); end
    $display("priority: load_ready=%b cpu_rst=%b", load_ready, cpu_rst);
  endtask

  task automatic test_full_load();
    logic [7:0] b;
    // Already in LOAD from the priority scenario.
    for (int i = 0; i < 256; i++) begin
      b = 8'(i);
      load_valid = 1'b1; load_data = b ^ 8'h5A; load_last = 1'b0;
      tick();
    end
    load_valid = 1'b0;
    pc_in = 8'h00; #1;
    checks++; if (prog_len !== 9'd256) begin failures++; $display("FAIL full_prog_len: got %0d want 256", prog_len); end
    checks++; if (cpu_rst !== 1'b0) begin failures++; $display("FAIL full_cpu_rst: got %b want 0", cpu_rst); end
    checks++; if (load_ready !== 1'b0) begin failures++; $display("FAIL full_load_ready: got %b want 0", load_ready); end
    checks++; if (instruction !== 8'h5A) begin failures++; $display("FAIL full_pc00: got %h want 5a", instruction); end
    pc_in = 8'h80; #1;
    checks++; if (instruction !== 8'hDA) begin failures++; $display("FAIL full_pc80: got %h want da", instruction); end
    pc_in = 8'hFF; #1;
    checks++; if (instruction !== 8'hA5) begin failures++; $display("FAIL full_pcff: got %h want a5", instruction); end
    tick(); tick(); tick();
    checks++; if (halted !== 1'b0) begin failures++; $display("FAIL full_halted: got %b want 0", halted); end
    checks++; if (instruction !== 8'hA5) begin failures++; $display("FAIL full_pcff_hold: got %h want a5", instruction); end
    $display("full_load: prog_len=%0d halted=%b", prog_len, halted);
  endtask

  task automatic test_reset_midload();
    load_start = 1'b1; tick(); load_start = 1'b0;
    load_valid = 1'b1; load_data = 8'h01; tick();
    load_valid = 1'b1; load_data = 8'h02; tick();
    load_data = 8'h03;
    #2 RST = 1'b1;
    #1;
    checks++; if (load_ready !== 1'b0) begin failures++; $display("FAIL midload_load_ready: got %b want 0", load_ready); end
    checks++; if (prog_len !== 9'd0) begin failures++; $display("FAIL midload_prog_len: got %0d want 0", prog_len); end
    checks++; if (cpu_rst !== 1'b1) begin failures++; $display("FAIL midload_cpu_rst: got %b want 1", cpu_rst); end
    tick();
    RST = 1'b0; load_valid = 1'b0;
    run_start = 1'b1; tick(); run_start = 1'b0;
    checks++; if (cpu_rst !== 1'b1) begin failures++; $display("FAIL midload_run_ignored: got %b want 1", cpu_rst); end
    tick();
    checks++; if (cpu_rst !== 1'b1) begin failures++; $display("FAIL midload_run_ignored2: got %b want 1", cpu_rst); end
    checks++; if (instruction !== 8'hC3) begin failures++; $display("FAIL midload_instr: got %h want c3", instruction); end
    checks++; if (load_ready !== 1'b0) begin failures++; $display("FAIL midload_idle_ready: got %b want 0", load_ready); end
    $display("reset_midload: cpu_rst=%b prog_len=%0d", cpu_rst, prog_len);
  endtask

  initial begin
    test_reset();
    test_load3();
    test_runoff();
    test_rerun();
    test_priority();
    test_full_load();
    test_reset_midload();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/instr_fetch_loader.md
Name: instr_fetch_loader

Overview:
- Instruction-side stage directly upstream of the 8-bit single-cycle microprocessor core.
- Holds the program in a local instruction RAM that is filled through a byte-wide valid/ready load port.
- Drives the core's `instruction` input combinationally from the core's PC output.
- Owns the core's reset during loading, runs the program, and substitutes a self-loop halt instruction once the PC leaves the loaded program.

Parameters:
- DEPTH, 256, instruction RAM words; PC is 8 bits, so max 256.
- HALT_INSTR, 8'hC3, team-standard branch-to-self encoding (opcode 11, imm 2'b11 = -1).
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, shared with the core.
- RST  in  1  asynchronous, active-high reset.
- load_start  in  1  pulse; begin a new program load.
- load_valid  in  1  load byte present.
- load_data  in  8  instruction byte.
- load_last  in  1  qualifies the final byte of the program.
- load_ready  out  1  loader accepts a byte this cycle.
- run_start  in  1  pulse; rerun the loaded program from PC 0 without reloading.
- pc_in  in  8  from core PCOutput.
- instruction  out  8  to core instruction input.
- cpu_rst  out  1  to core RST; registered.
- halted  out  1  program ran off its end.
- prog_len  out  9  loaded program length, 0..256.
- instr_count  out  CNT_W  cycles spent in RUN; saturating.

Behaviour:
- Clock and reset: one clock, `clk`. Reset `RST` is asynchronous and active-high.
- Reset values:
  - state = IDLE, cpu_rst = 1, load_ready = 0, halted = 0, prog_len = 0, instr_count = 0, wr_ptr = 0.
  - RAM contents are not reset.
- States: IDLE, LOAD, RUN, HALT.
- IDLE:
  - cpu_rst = 1, instruction = HALT_INSTR.
  - load_start -> LOAD.
  - run_start with prog_len != 0 -> RUN.
  - run_start with prog_len == 0 is ignored.
- LOAD:
  - On entry: wr_ptr = 0, prog_len = 0, halted = 0, cpu_rst = 1.
  - load_ready = 1 throughout the state.
  - A beat is accepted when load_valid && load_ready. On acceptance: mem[wr_ptr] <= load_data and wr_ptr++.
  - Accepted beat with load_last -> prog_len = wr_ptr+1, next state RUN.
  - Accepted beat at wr_ptr == DEPTH-1 is treated as last, with prog_len = DEPTH, even without load_last.
  - load_start and run_start are ignored in LOAD.
  - instruction = HALT_INSTR while in LOAD.
- Entering RUN (from LOAD or via run_start):
  - cpu_rst deasserts on the first RUN cycle (registered), so the core PC reads 0 on that cycle.
  - instr_count is cleared on entry, then increments each RUN cycle and saturates at all-ones.
- RUN:
  - instruction = mem[pc_in] when {1'b0,pc_in} < prog_len, else HALT_INSTR. The read is combinational, with zero cycle latency to the core.
  - When pc_in >= prog_len: halted <= 1 and next state HALT. HALT_INSTR is already presented in that same cycle.
  - load_start in RUN -> LOAD, and cpu_rst reasserts next cycle.
- HALT:
  - cpu_rst stays 0 so core registers and display are preserved.
  - instruction = HALT_INSTR, halted = 1, instr_count frozen.
  - load_start -> LOAD.
  - run_start -> IDLE for one cycle (cpu_rst = 1), then RUN. halted clears on leaving HALT.
- Simultaneous events: load_start has priority over run_start in the same cycle.
- Reset during LOAD: returns to IDLE with prog_len = 0. The partial image is abandoned, and run_start is then ignored until a new load completes.
- Width rule: prog_len is 9 bits so a full 256-byte program is representable, and every comparison is done at 9 bits.

Decomposition:
- Shared package:
  - State encoding localparams (IDLE/LOAD/RUN/HALT).
  - HALT_INSTR value.
  - Opcode field constants (bits [7:6]) shared with the control unit.
- One sub-module: `instr_ram`, DEPTH x 8, with synchronous write and asynchronous read. The FSM, pointer and counter stay in the top.

Test Plan:
- **Reset and idle:** RST pulse mid-cycle -> cpu_rst = 1, load_ready = 0, prog_len = 0, instruction = 8'hC3 immediately (asynchronous).
- **Load 3 bytes:** 3 bytes (8'h11, 8'h22, 8'h33 with load_last), one gap cycle of load_valid = 0 -> prog_len = 3, cpu_rst = 0 the cycle after the last beat. pc_in = 0/1/2 -> instruction 11/22/33.
- **Run-off halt:** after the 3-byte load, pc_in = 3 -> instruction = 8'hC3 the same cycle, halted = 1 next cycle, and instr_count holds its value while pc_in stays 3.
- **Full-depth load:** 256 beats, none flagged last -> prog_len = 9'd256. pc_in = 8'hFF returns the last byte and halted never asserts.
- **Reset mid-load:** RST after 2 of 5 beats -> IDLE, prog_len = 0. A following run_start leaves cpu_rst = 1.
- **Rerun and priority:**
  - run_start in HALT -> one cycle cpu_rst = 1, then RUN with instr_count restarting at 0.
  - load_start and run_start together -> LOAD.
